// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - command, ALU and response bundle of the ALU driver
//
// Groups the three handshake/bus groups of alu_driver:
//   cmd_* : command in     (cmd_valid/cmd_ready handshake, op, operands, chain)
//   alu_* : ALU bus        (operands/op out, result and flags in)
//   rsp_* : response out   (rsp_valid/rsp_ready handshake, result, flags)
// modport master : requester side (issues commands, models the ALU, takes responses)
// modport slave  : the driver itself
interface alu_driver_if #(
    parameter int WIDTH = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_z;
    logic             alu_cout;
    logic             alu_sign;
    logic             alu_ov;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic [2:0]       rsp_flags;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        output alu_z, alu_cout, alu_sign, alu_ov,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_z, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        input  alu_z, alu_cout, alu_sign, alu_ov,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_z, rsp_flags
    );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - sequences one command at a time through an external ALU
//
// Accepts a command in IDLE, drives the operands/op onto the ALU bus, lets the
// ALU settle, captures result and {cout, sign, ov} and presents them as a
// response held until the consumer takes it.
//
// Parameters:
//   WIDTH  : operand/result width
//   SETTLE : cycles (1..15) the settle counter runs before the result is captured
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_driver_if.slave (cmd_*, alu_*, rsp_* groups)
// Optional feature macro: ALU_DRV_CHAIN_EN
//   defined   : chain register holds the last captured result; cmd_chain=1 at
//               acceptance drives alu_a from it instead of cmd_a
//   undefined : no chain register, cmd_chain is ignored
module alu_driver #(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_driver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       cnt;
    // First ISSUE cycle: operands have only just been registered onto the bus,
    // so the settle count starts one cycle later.
    logic             launch;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_z_q;
    logic [2:0]       rsp_flags_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] next_a;

`ifdef ALU_DRV_CHAIN_EN
    logic [WIDTH-1:0] chain_q;
    assign next_a = bus.cmd_chain ? chain_q : bus.cmd_a;
`else
    logic unused_chain;
    assign unused_chain = bus.cmd_chain;
    assign next_a       = bus.cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            launch      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_flags_q <= 3'b000;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'd0;
`ifdef ALU_DRV_CHAIN_EN
            chain_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready_q is 1 exactly in IDLE
                    if (bus.cmd_valid && cmd_ready_q) begin
                        alu_a_q     <= next_a;
                        alu_b_q     <= bus.cmd_b;
                        alu_op_q    <= bus.cmd_op;
                        cnt         <= SETTLE_LOAD;
                        launch      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (launch) begin
                        launch <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        rsp_z_q     <= bus.alu_z;
                        rsp_flags_q <= {bus.alu_cout, bus.alu_sign, bus.alu_ov};
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
`ifdef ALU_DRV_CHAIN_EN
                        chain_q     <= bus.alu_z;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // No same-cycle accept: cmd_ready rises with the return to IDLE
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, operand/result width.
REQ-002 SHALL provide parameter SETTLE, default 1, cycles (1..15) operands held on the ALU bus before result capture.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port cmd_valid  input  1  command present.
REQ-006 SHALL provide port cmd_ready  output  1  driver can accept a command.
REQ-007 SHALL provide port cmd_op  input  3  ALU op code: 0 neg, 1 shl B, 2 and, 3 or, 4 xor, 5 not, 6 add, 7 sub.
REQ-008 SHALL provide port cmd_a, cmd_b  input  WIDTH each  operands.
REQ-009 SHALL provide port cmd_chain  input  1  use previous result as A; ignored unless ALU_DRV_CHAIN_EN is defined.
REQ-010 SHALL provide port alu_a, alu_b  output  WIDTH each  operands driven to the ALU.
REQ-011 SHALL provide port alu_op  output  3  op driven to the ALU.
REQ-012 SHALL provide port alu_z  input  WIDTH  ALU result.
REQ-013 SHALL provide port alu_cout, alu_sign, alu_ov  input  1 each  ALU flags.
REQ-014 SHALL provide port rsp_valid  output  1  response present.
REQ-015 SHALL provide port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL provide port rsp_z  output  WIDTH  captured result.
REQ-017 SHALL provide port rsp_flags  output  3  captured {cout, sign, ov}.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, RESP; reset state IDLE.
REQ-019 SHALL assert cmd_ready only in IDLE; command accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-020 SHALL on acceptance register cmd_a/cmd_b/cmd_op onto alu_a/alu_b/alu_op and enter ISSUE with settle counter loaded to SETTLE-1.
REQ-021 SHALL hold alu_a/alu_b/alu_op stable throughout ISSUE and RESP, and keep them at last values in IDLE.
REQ-022 SHALL in ISSUE decrement the counter each cycle; when counter is 0, capture alu_z into rsp_z and {alu_cout, alu_sign, alu_ov} into rsp_flags and enter RESP.
REQ-023 SHALL give latency: rsp_valid rises SETTLE+1 cycles after the accepting edge (SETTLE=1: 2 cycles).
REQ-024 SHALL assert rsp_valid only in RESP; rsp_z/rsp_flags stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL on rsp_valid and rsp_ready both 1 return to IDLE; cmd_ready is 1 the following cycle (no same-cycle accept in RESP).
REQ-026 SHALL ignore cmd_valid and all cmd_* changes outside IDLE.
REQ-027 SHALL pass rsp_z and flags unmodified from the ALU; no width extension or saturation.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, cmd_ready 1, rsp_valid 0, rsp_z 0, rsp_flags 0, alu_a 0, alu_b 0, alu_op 0, counter 0, chain register 0.
REQ-029 SHALL abort any in-flight command on reset with no response produced after release.

Configuration
REQ-030 SHALL, with ALU_DRV_CHAIN_EN defined, keep a chain register updated with rsp_z on each capture and, when cmd_chain=1 at acceptance, drive alu_a from the chain register instead of cmd_a.
REQ-031 SHALL, without ALU_DRV_CHAIN_EN, omit the chain register and always drive alu_a from cmd_a.

Verification
REQ-032 SHALL cover: add 12'h005+12'h003, SETTLE=1 -> rsp_valid 2 cycles after accept, rsp_z 12'h008, flags 3'b000.
REQ-033 SHALL cover: add 12'h7FF+12'h001 -> rsp_z 12'h800, flags {cout=0,sign=1,ov=1}.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_z, rsp_flags, alu_* unchanged; cmd_valid pulses ignored.
REQ-035 SHALL cover: rst_n low during ISSUE -> outputs at reset values in same cycle; no rsp_valid after release until a new command.
REQ-036 SHALL cover (ALU_DRV_CHAIN_EN): add 2+3 then chained add B=4 -> second rsp_z 12'h009; without macro, cmd_chain ignored, result cmd_a+4.
REQ-037 SHALL cover: SETTLE=4 with back-to-back commands -> each rsp_valid 5 cycles after its accept, cmd_ready low from accept until cycle after response handshake.
